// File: rtl/tg2_csr_pkg.sv
// tg2_csr_pkg: TG2 configuration register map constants shared by the TG2 blocks
package tg2_csr_pkg;
  localparam logic [31:0] TG_START_ADDR = 32'h0000_0010;
endpackage

// File: rtl/tg2_perf_pkg.sv
// tg2_perf_pkg: state and result encodings for the TG2 performance monitor
package tg2_perf_pkg;
  typedef enum logic [1:0] {PERF_IDLE, PERF_RUN, PERF_DONE} perf_state_e;
  localparam logic [1:0] PERF_RES_NONE    = 2'b00;
  localparam logic [1:0] PERF_RES_PASS    = 2'b01;
  localparam logic [1:0] PERF_RES_FAIL    = 2'b10;
  localparam logic [1:0] PERF_RES_TIMEOUT = 2'b11;
endpackage

// File: rtl/tg2_perf_ch.sv
// tg2_perf_ch: one monitor channel - start/completion detect, IDLE/RUN/DONE FSM, saturating counters
// Ports: clk, local_rst_n_sync (async, active-low); cfg_write/cfg_waitrequest/cfg_address detect the
// start write; tg_pass/tg_fail/tg_timeout status levels; wbeat/rbeat data beats; outputs busy,
// done_pulse, result, clock_count, wr_beats, rd_beats, overflow (all registered).
// Beat counters are built only when TG2_PERF_BEAT_CNT_EN is defined.
module tg2_perf_ch import tg2_perf_pkg::*; #(
  parameter int CNT_W = 64,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              local_rst_n_sync,
  input  logic              cfg_write,
  input  logic              cfg_waitrequest,
  input  logic [ADDR_W-1:0] cfg_address,
  input  logic              tg_pass,
  input  logic              tg_fail,
  input  logic              tg_timeout,
  input  logic              wbeat,
  input  logic              rbeat,
  output logic              busy,
  output logic              done_pulse,
  output logic [1:0]        result,
  output logic [CNT_W-1:0]  clock_count,
  output logic [CNT_W-1:0]  wr_beats,
  output logic [CNT_W-1:0]  rd_beats,
  output logic              overflow
);
  perf_state_e r_state;
  logic r_start_q, r_comp_q, r_done_pulse, r_ovf;
  logic [1:0] r_result;
  logic [CNT_W-1:0] r_clk_cnt;
  logic w_comp, w_comp_rise, w_clk_max, w_beat_ovf;
  logic [1:0] w_res;
  assign w_comp = tg_pass | tg_fail | tg_timeout;
  // edge detect so status left high from a previous test cannot end a new one
  assign w_comp_rise = w_comp & ~r_comp_q;
  assign w_clk_max = &r_clk_cnt;
  assign w_res = tg_timeout ? PERF_RES_TIMEOUT : tg_fail ? PERF_RES_FAIL : PERF_RES_PASS;
  always_ff @(posedge clk or negedge local_rst_n_sync)
    if (!local_rst_n_sync) begin
      r_state <= PERF_IDLE;
      r_start_q <= 1'b0;
      r_comp_q <= 1'b0;
      r_done_pulse <= 1'b0;
      r_ovf <= 1'b0;
      r_result <= PERF_RES_NONE;
      r_clk_cnt <= '0;
    end else begin
      r_start_q <= cfg_write & ~cfg_waitrequest & (cfg_address == START_ADDR);
      r_comp_q <= w_comp;
      r_done_pulse <= 1'b0;
      if (r_start_q) begin
        r_state <= PERF_RUN;
        r_ovf <= 1'b0;
        r_result <= PERF_RES_NONE;
        r_clk_cnt <= '0;
      end else if (r_state == PERF_RUN) begin
        r_clk_cnt <= w_clk_max ? r_clk_cnt : r_clk_cnt + CNT_W'(1);
        r_ovf <= r_ovf | w_clk_max | w_beat_ovf;
        if (w_comp_rise) begin
          r_state <= PERF_DONE;
          r_result <= w_res;
          r_done_pulse <= 1'b1;
        end
      end
    end
`ifdef TG2_PERF_BEAT_CNT_EN
  logic [CNT_W-1:0] r_wr_cnt, r_rd_cnt;
  logic w_wr_max, w_rd_max;
  assign w_wr_max = &r_wr_cnt;
  assign w_rd_max = &r_rd_cnt;
  assign w_beat_ovf = (wbeat & w_wr_max) | (rbeat & w_rd_max);
  always_ff @(posedge clk or negedge local_rst_n_sync)
    if (!local_rst_n_sync) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else if (r_start_q) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else if (r_state == PERF_RUN) begin
      r_wr_cnt <= w_wr_max ? r_wr_cnt : r_wr_cnt + CNT_W'(wbeat);
      r_rd_cnt <= w_rd_max ? r_rd_cnt : r_rd_cnt + CNT_W'(rbeat);
    end
  assign wr_beats = r_wr_cnt;
  assign rd_beats = r_rd_cnt;
`else
  logic w_unused;
  assign w_unused = wbeat | rbeat;
  assign w_beat_ovf = 1'b0;
  assign wr_beats = '0;
  assign rd_beats = '0;
`endif
  assign busy = r_state == PERF_RUN;
  assign done_pulse = r_done_pulse;
  assign result = r_result;
  assign clock_count = r_clk_cnt;
  assign overflow = r_ovf;
endmodule

// File: rtl/tg2_perf_mon.sv
// tg2_perf_mon: multi-channel TG2 performance monitor, one independent tg2_perf_ch per channel
// Ports: clk, local_rst_n_sync (async, active-low); per-channel packed cfg_* bus, tg_* status,
// wbeat/rbeat; per-channel packed outputs busy, done_pulse, result[2], clock_count, wr_beats,
// rd_beats, overflow. Define TG2_PERF_BEAT_CNT_EN to build the beat counters.
module tg2_perf_mon import tg2_csr_pkg::*; #(
  parameter int NUM_CH = 1,
  parameter int CNT_W = 64,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(TG_START_ADDR)
) (
  input  logic                     clk,
  input  logic                     local_rst_n_sync,
  input  logic [NUM_CH-1:0]        cfg_write,
  input  logic [NUM_CH-1:0]        cfg_waitrequest,
  input  logic [NUM_CH*ADDR_W-1:0] cfg_address,
  input  logic [NUM_CH-1:0]        tg_pass,
  input  logic [NUM_CH-1:0]        tg_fail,
  input  logic [NUM_CH-1:0]        tg_timeout,
  input  logic [NUM_CH-1:0]        wbeat,
  input  logic [NUM_CH-1:0]        rbeat,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH-1:0]        done_pulse,
  output logic [NUM_CH*2-1:0]      result,
  output logic [NUM_CH*CNT_W-1:0]  clock_count,
  output logic [NUM_CH*CNT_W-1:0]  wr_beats,
  output logic [NUM_CH*CNT_W-1:0]  rd_beats,
  output logic [NUM_CH-1:0]        overflow
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tg2_perf_ch #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .START_ADDR(START_ADDR)) u_ch (
      .clk(clk),
      .local_rst_n_sync(local_rst_n_sync),
      .cfg_write(cfg_write[i]),
      .cfg_waitrequest(cfg_waitrequest[i]),
      .cfg_address(cfg_address[i*ADDR_W +: ADDR_W]),
      .tg_pass(tg_pass[i]),
      .tg_fail(tg_fail[i]),
      .tg_timeout(tg_timeout[i]),
      .wbeat(wbeat[i]),
      .rbeat(rbeat[i]),
      .busy(busy[i]),
      .done_pulse(done_pulse[i]),
      .result(result[i*2 +: 2]),
      .clock_count(clock_count[i*CNT_W +: CNT_W]),
      .wr_beats(wr_beats[i*CNT_W +: CNT_W]),
      .rd_beats(rd_beats[i*CNT_W +: CNT_W]),
      .overflow(overflow[i])
    );
  end
endmodule

// File: tb/tb_tg2_perf_mon.sv
// tb_tg2_perf_mon: directed and random checks of tg2_perf_mon against a behavioural model
module tb_tg2_perf_mon;
  import tg2_csr_pkg::*;
  localparam int N = 4;
  localparam int W = 32;
  localparam int A = 32;
  localparam logic [W-1:0] MAX = '1;
  logic clk = 1'b0;
  logic local_rst_n_sync = 1'b0;
  logic [N-1:0] cfg_write = '0, cfg_waitrequest = '0, tg_pass = '0, tg_fail = '0, tg_timeout = '0;
  logic [N-1:0] wbeat = '0, rbeat = '0;
  logic [N*A-1:0] cfg_address = '0;
  logic [N-1:0] busy, done_pulse, overflow;
  logic [N*2-1:0] result;
  logic [N*W-1:0] clock_count, wr_beats, rd_beats;
  int total = 0;
  int bad = 0;
  bit m_run[N], m_sq[N], m_cq[N], m_dp[N], m_ovf[N];
  logic [1:0] m_res[N];
  logic [W-1:0] m_cnt[N], m_wr[N], m_rd[N];

  tg2_perf_mon #(.NUM_CH(N), .CNT_W(W), .ADDR_W(A)) dut (
    .clk(clk), .local_rst_n_sync(local_rst_n_sync),
    .cfg_write(cfg_write), .cfg_waitrequest(cfg_waitrequest), .cfg_address(cfg_address),
    .tg_pass(tg_pass), .tg_fail(tg_fail), .tg_timeout(tg_timeout),
    .wbeat(wbeat), .rbeat(rbeat),
    .busy(busy), .done_pulse(done_pulse), .result(result),
    .clock_count(clock_count), .wr_beats(wr_beats), .rd_beats(rd_beats), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v, input bit en, inout bit ovf);
    if (!en) return v;
    if (v == MAX) begin
      ovf = 1;
      return v;
    end
    return v + 1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_run[c] = 0; m_sq[c] = 0; m_cq[c] = 0; m_dp[c] = 0; m_ovf[c] = 0;
      m_res[c] = 2'b00; m_cnt[c] = '0; m_wr[c] = '0; m_rd[c] = '0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < N; c++) begin
      bit comp, rise, nsq;
      comp = tg_pass[c] | tg_fail[c] | tg_timeout[c];
      rise = comp && !m_cq[c];
      nsq = cfg_write[c] && !cfg_waitrequest[c] && cfg_address[c*A +: A] == TG_START_ADDR;
      m_dp[c] = 0;
      if (m_sq[c]) begin
        m_run[c] = 1; m_ovf[c] = 0; m_res[c] = 2'b00;
        m_cnt[c] = '0; m_wr[c] = '0; m_rd[c] = '0;
      end else if (m_run[c]) begin
        m_cnt[c] = sat_inc(m_cnt[c], 1, m_ovf[c]);
`ifdef TG2_PERF_BEAT_CNT_EN
        m_wr[c] = sat_inc(m_wr[c], wbeat[c], m_ovf[c]);
        m_rd[c] = sat_inc(m_rd[c], rbeat[c], m_ovf[c]);
`endif
        if (rise) begin
          m_run[c] = 0;
          m_dp[c] = 1;
          m_res[c] = tg_timeout[c] ? 2'd3 : tg_fail[c] ? 2'd2 : 2'd1;
        end
      end
      m_cq[c] = comp;
      m_sq[c] = nsq;
    end
  endtask

  task automatic compare();
    logic [N-1:0] eb, ed, eo;
    logic [N*2-1:0] er;
    logic [N*W-1:0] ec, ew, erd;
    for (int c = 0; c < N; c++) begin
      eb[c] = m_run[c]; ed[c] = m_dp[c]; eo[c] = m_ovf[c];
      er[c*2 +: 2] = m_res[c];
      ec[c*W +: W] = m_cnt[c]; ew[c*W +: W] = m_wr[c]; erd[c*W +: W] = m_rd[c];
    end
    chk("busy", 128'(busy), 128'(eb));
    chk("done_pulse", 128'(done_pulse), 128'(ed));
    chk("result", 128'(result), 128'(er));
    chk("clock_count", 128'(clock_count), 128'(ec));
    chk("wr_beats", 128'(wr_beats), 128'(ew));
    chk("rd_beats", 128'(rd_beats), 128'(erd));
    chk("overflow", 128'(overflow), 128'(eo));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic start_wr(input int c);
    cfg_write[c] = 1'b1;
    cfg_waitrequest[c] = 1'b0;
    cfg_address[c*A +: A] = TG_START_ADDR;
    tick();
    cfg_write[c] = 1'b0;
    cfg_address[c*A +: A] = 32'h0000_0100;
  endtask

  initial begin
    model_reset();
    #12;
    compare();
    local_rst_n_sync = 1'b1;
    tick();
    // start and pass on channel 0
    start_wr(0);
    tick();
    chk("t1_busy", 128'(busy[0]), 128'(1));
    repeat (99) tick();
    tg_pass[0] = 1'b1;
    tick();
    chk("t1_cnt", 128'(clock_count[0 +: W]), 128'(100));
    chk("t1_res", 128'(result[1:0]), 128'(1));
    chk("t1_dp", 128'(done_pulse[0]), 128'(1));
    tick();
    chk("t1_dp_end", 128'(done_pulse[0]), 128'(0));
    // beat counting on channel 1, including a beat on the start-clear edge
    start_wr(1);
    wbeat[1] = 1'b1;
    tick();
    for (int i = 0; i < 60; i++) begin
      wbeat[1] = i < 37;
      rbeat[1] = i < 53;
      tick();
    end
    wbeat[1] = 1'b0;
    rbeat[1] = 1'b0;
    tg_pass[1] = 1'b1;
    tick();
`ifdef TG2_PERF_BEAT_CNT_EN
    chk("t2_wr", 128'(wr_beats[W +: W]), 128'(37));
    chk("t2_rd", 128'(rd_beats[W +: W]), 128'(53));
`else
    chk("t2_wr", 128'(wr_beats[W +: W]), 128'(0));
    chk("t2_rd", 128'(rd_beats[W +: W]), 128'(0));
`endif
    // stale fail from the previous test must not end the next one
    tg_pass[0] = 1'b0;
    tg_fail[0] = 1'b1;
    tick();
    tick();
    start_wr(0);
    tick();
    tg_fail[0] = 1'b0;
    repeat (19) tick();
    tg_pass[0] = 1'b1;
    tick();
    chk("t3_cnt", 128'(clock_count[0 +: W]), 128'(20));
    chk("t3_res", 128'(result[1:0]), 128'(1));
    // restart mid-run clears the counters
    tg_pass[0] = 1'b0;
    tick();
    start_wr(0);
    repeat (10) tick();
    start_wr(0);
    tick();
    chk("t3_restart_cnt", 128'(clock_count[0 +: W]), 128'(0));
    repeat (5) tick();
    chk("t3_cont_cnt", 128'(clock_count[0 +: W]), 128'(5));
    // start and completion on the same edge: start wins
    tg_pass[1] = 1'b0;
    tick();
    start_wr(1);
    repeat (6) tick();
    start_wr(1);
    tg_pass[1] = 1'b1;
    tick();
    chk("t4_busy", 128'(busy[1]), 128'(1));
    chk("t4_dp", 128'(done_pulse[1]), 128'(0));
    chk("t4_cnt", 128'(clock_count[W +: W]), 128'(0));
    tg_pass[1] = 1'b0;
    tick();
    tg_fail[1] = 1'b1;
    tg_timeout[1] = 1'b1;
    tick();
    chk("t4_res", 128'(result[3:2]), 128'(3));
    // saturation on channel 3
    start_wr(3);
    repeat (4) tick();
    force dut.g_ch[3].u_ch.r_clk_cnt = 32'hFFFF_FFF0;
    release dut.g_ch[3].u_ch.r_clk_cnt;
    m_cnt[3] = 32'hFFFF_FFF0;
    repeat (20) tick();
    chk("t5_sat", 128'(clock_count[3*W +: W]), 128'(32'hFFFF_FFFF));
    chk("t5_ovf", 128'(overflow[3]), 128'(1));
    // reset in the middle of a run
    start_wr(0);
    start_wr(2);
    repeat (8) tick();
    #2;
    local_rst_n_sync = 1'b0;
    #1;
    model_reset();
    compare();
    tg_pass = '0; tg_fail = '0; tg_timeout = '0; wbeat = '0; rbeat = '0;
    local_rst_n_sync = 1'b1;
    tick();
    start_wr(2);
    tick();
    chk("t6_busy", 128'(busy), 128'(4'b0100));
    // random traffic on all channels
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < N; c++) begin
        cfg_write[c] = $urandom_range(0, 24) == 0;
        cfg_waitrequest[c] = $urandom_range(0, 3) == 0;
        cfg_address[c*A +: A] = $urandom_range(0, 1) ? TG_START_ADDR : A'($urandom_range(0, 63));
        if ($urandom_range(0, 29) == 0) tg_pass[c] = ~tg_pass[c];
        if ($urandom_range(0, 39) == 0) tg_fail[c] = ~tg_fail[c];
        if ($urandom_range(0, 49) == 0) tg_timeout[c] = ~tg_timeout[c];
        wbeat[c] = $urandom_range(0, 1) == 1;
        rbeat[c] = $urandom_range(0, 2) == 0;
      end
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
